// File: rtl/sram_bus_arbiter_pkg.sv
// Shared types for the SRAM bus arbiter: owner ids recorded per accepted
// address phase and a small helper used by the round-robin policy.
package sram_bus_arbiter_pkg;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  function automatic owner_e other_owner(input owner_e o);
    return (o == OWNER_INST) ? OWNER_DATA : OWNER_INST;
  endfunction

endpackage

// File: rtl/sram_bus_arbiter_owner_fifo.sv
// In-order FIFO of 1-bit owner ids, one entry per accepted address phase
// that has not yet seen its response. Depth must be a power of two.
module owner_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic head,
  output logic full,
  output logic empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] mem_q, mem_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_id;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; count/pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like bus port between the IF and EX masters and routes each
// response to its owner. Define ARB_RR_EN for round-robin, else data > inst.
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int OUTST_DEPTH = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                sram_req,
  output logic                sram_wr,
  output logic [DATA_W/8-1:0] sram_wstrb,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic                sram_addr_ok,
  input  logic                sram_data_ok,
  input  logic [DATA_W-1:0]   sram_rdata
);

  owner_e grant;
  owner_e both_pick;
  owner_e locked_owner_q, locked_owner_d;
  logic   lock_q, lock_d;
  logic   granted_req;
  logic   req_ok;
  logic   handshake;
  logic   fifo_full;
  logic   fifo_empty;
  logic   fifo_head;
  logic   pop;

`ifdef ARB_RR_EN
  owner_e last_served_q, last_served_d;

  assign both_pick = other_owner(last_served_q);

  always_comb begin
    last_served_d = last_served_q;
    if (handshake) last_served_d = grant;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_served_q <= OWNER_DATA;
    else       last_served_q <= last_served_d;
  end
`else
  assign both_pick = OWNER_DATA;
`endif

  always_comb begin
    if (lock_q)                     grant = locked_owner_q;
    else if (inst_req && data_req)  grant = both_pick;
    else if (data_req)              grant = OWNER_DATA;
    else                            grant = OWNER_INST;
  end

  assign granted_req = (grant == OWNER_DATA) ? data_req : inst_req;
  assign req_ok      = granted_req & ~fifo_full;
  assign handshake   = req_ok & sram_addr_ok;

  // Reset only gates the visible request; internal state is held by the async reset.
  assign sram_req     = req_ok & ~reset;
  assign inst_addr_ok = sram_req & sram_addr_ok & (grant == OWNER_INST);
  assign data_addr_ok = sram_req & sram_addr_ok & (grant == OWNER_DATA);

  assign sram_wr    = (grant == OWNER_DATA) ? data_wr    : 1'b0;
  assign sram_wstrb = (grant == OWNER_DATA) ? data_wstrb : '0;
  assign sram_addr  = (grant == OWNER_DATA) ? data_addr  : inst_addr;
  assign sram_wdata = (grant == OWNER_DATA) ? data_wdata : '0;

  // Holding the grant while the bus stalls keeps an address phase from being preempted.
  always_comb begin
    lock_d         = lock_q;
    locked_owner_d = locked_owner_q;
    if (handshake) begin
      lock_d = 1'b0;
    end else if (req_ok) begin
      lock_d         = 1'b1;
      locked_owner_d = grant;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_q         <= 1'b0;
      locked_owner_q <= OWNER_INST;
    end else begin
      lock_q         <= lock_d;
      locked_owner_q <= locked_owner_d;
    end
  end

  assign pop = sram_data_ok & ~fifo_empty;

  owner_fifo #(
    .DEPTH(OUTST_DEPTH)
  ) u_owner_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (handshake),
    .push_id(grant),
    .pop    (pop),
    .head   (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign inst_data_ok = pop & (fifo_head == OWNER_INST);
  assign data_data_ok = pop & (fifo_head == OWNER_DATA);
  assign inst_rdata   = sram_rdata;
  assign data_rdata   = sram_rdata;

endmodule
